// File: rtl/fwd_operand_sel_if.sv
// Decode-side and forwarding-side signals of the operand forwarding unit.
// master drives the decode slot and pipeline data; slave is the forwarding unit.
interface fwd_operand_sel_if #(
    parameter int REG_W  = 4,
    parameter int DATA_W = 4
);
    logic              id_valid;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic              id_wr_en;
    logic              id_is_load;
    logic              flush;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] mem_load_data;
    logic              fwd_a_sel;
    logic              fwd_b_sel;
    logic              fwd_a_en;
    logic              fwd_b_en;
    logic [DATA_W-1:0] fwd_a_data;
    logic [DATA_W-1:0] fwd_b_data;
    logic              stall;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_wr_en, id_is_load, flush,
               ex_result, mem_load_data,
        input  fwd_a_sel, fwd_b_sel, fwd_a_en, fwd_b_en, fwd_a_data, fwd_b_data,
               stall
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_wr_en, id_is_load, flush,
               ex_result, mem_load_data,
        output fwd_a_sel, fwd_b_sel, fwd_a_en, fwd_b_en, fwd_a_data, fwd_b_data,
               stall
    );
endinterface

// File: rtl/fwd_operand_sel.sv
// Operand forwarding and load-use stall unit; outputs registered into the EX cycle.
// Define FWD_MEM_EN to forward from MEM; otherwise a MEM hit stalls one cycle instead.
module fwd_operand_sel #(
    parameter int REG_W  = 4,
    parameter int DATA_W = 4
) (
    input logic              clk,
    input logic              reset,
    fwd_operand_sel_if.slave bus
);
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             is_load;
    } entry_t;

    typedef struct packed {
        logic              sel;
        logic              en;
        logic [DATA_W-1:0] data;
    } op_t;

    entry_t            exe_q;
    entry_t            mem_q;
    logic [DATA_W-1:0] mem_value_q;
    op_t               a_q;
    op_t               b_q;

    logic              live;
    logic              hit_exe_a;
    logic              hit_exe_b;
    logic              hit_mem_a;
    logic              hit_mem_b;
    logic              load_stall;
    logic              mem_stall;
    logic              stall_c;
    logic [DATA_W-1:0] mem_fwd_data;
    op_t               a_next;
    op_t               b_next;

    // EXE is the youngest writer, so it takes precedence over MEM.
    function automatic op_t resolve(input logic hit_exe, input logic hit_mem,
                                    input logic [DATA_W-1:0] exe_data,
                                    input logic [DATA_W-1:0] mem_data);
        op_t r;
        r = '{sel: 1'b0, en: 1'b1, data: '0};
        if (hit_exe) begin
            r = '{sel: 1'b1, en: 1'b1, data: exe_data};
        end else if (hit_mem) begin
            r = '{sel: 1'b1, en: 1'b1, data: mem_data};
        end
        return r;
    endfunction

    always_comb begin
        live      = bus.id_valid & ~bus.flush;
        hit_exe_a = exe_q.valid & exe_q.wr & (exe_q.rd == bus.id_rs) & (bus.id_rs != '0);
        hit_exe_b = exe_q.valid & exe_q.wr & (exe_q.rd == bus.id_rt) & (bus.id_rt != '0);
        hit_mem_a = mem_q.valid & mem_q.wr & (mem_q.rd == bus.id_rs) & (bus.id_rs != '0);
        hit_mem_b = mem_q.valid & mem_q.wr & (mem_q.rd == bus.id_rt) & (bus.id_rt != '0);
        load_stall = (hit_exe_a | hit_exe_b) & exe_q.is_load;
`ifdef FWD_MEM_EN
        mem_stall = 1'b0;
`else
        // Only a MEM hit not already covered by an EXE hit needs the register file.
        mem_stall = (hit_mem_a & ~hit_exe_a) | (hit_mem_b & ~hit_exe_b);
`endif
        stall_c      = ~reset & live & (load_stall | mem_stall);
        mem_fwd_data = mem_q.is_load ? bus.mem_load_data : mem_value_q;
        a_next = '0;
        b_next = '0;
        if (live && !stall_c) begin
            a_next = resolve(hit_exe_a, hit_mem_a, bus.ex_result, mem_fwd_data);
            b_next = resolve(hit_exe_b, hit_mem_b, bus.ex_result, mem_fwd_data);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exe_q       <= '0;
            mem_q       <= '0;
            mem_value_q <= '0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            mem_q         <= exe_q;
            mem_value_q   <= bus.ex_result;
            exe_q.valid   <= live & ~stall_c;
            exe_q.rd      <= bus.id_rd;
            exe_q.wr      <= bus.id_wr_en;
            exe_q.is_load <= bus.id_is_load;
            a_q           <= a_next;
            b_q           <= b_next;
        end
    end

    assign bus.fwd_a_sel  = a_q.sel;
    assign bus.fwd_a_en   = a_q.en;
    assign bus.fwd_a_data = a_q.data;
    assign bus.fwd_b_sel  = b_q.sel;
    assign bus.fwd_b_en   = b_q.en;
    assign bus.fwd_b_data = b_q.data;
    assign bus.stall      = stall_c;
endmodule

// File: doc/fwd_operand_sel.md
# fwd_operand_sel

Operand-forwarding and load-use stall unit for the pipelined datapath. It tracks the destination register, write-enable and result of the two instructions ahead of decode. For each source operand of the decoding instruction, it produces the select, enable and bypass value that drive the downstream 4-bit 2:1 operand muxes: sel 0 picks the register file, sel 1 picks the bypass, and enable 0 forces the mux output to 0. Its outputs are registered so they are aligned with the instruction's EX cycle.

## Interface
- REG_W, 4, register address width; register 0 is hard-wired zero
- DATA_W, 4, operand/result width, matching the mux data width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_rs, id_rt  in  REG_W  source register numbers
- id_rd  in  REG_W  destination register number
- id_wr_en  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a load; its result arrives in MEM
- flush  in  1  squash the decode slot (branch taken)
- ex_result  in  DATA_W  ALU result of the instruction currently in EX
- mem_load_data  in  DATA_W  load data of the instruction currently in MEM
- fwd_a_sel, fwd_b_sel  out  1  mux select for rs / rt
- fwd_a_en, fwd_b_en  out  1  mux enable for rs / rt
- fwd_a_data, fwd_b_data  out  DATA_W  bypass value, to mux input b
- stall  out  1  combinational; hold PC and IF/ID, insert a bubble

## Operation
- The unit keeps two internal entries: EXE, the instruction in EX, and MEM, the instruction in MEM.
  - Each entry holds {valid, rd, wr, is_load}.
  - MEM also holds a value: ex_result captured when the instruction leaves EX.
- Each clock, the entries advance:
  - MEM <= EXE, with value <= ex_result.
  - EXE <= decode slot. EXE <= bubble (valid 0) when stall=1 or flush=1.
- A decode slot is live when id_valid=1 and flush=0.
- For each source s in {rs, rt}, a hit on entry X requires all of: X.valid, X.wr, X.rd==s, and s!=0.
- stall=1 when the decode slot is live and either source hits an EXE entry with is_load=1.
- Per-operand next-state, written into the output registers at the clock edge:
  - Slot not live, or stall=1: sel=0, en=0, data=0.
  - EXE hit, non-load (priority 1): sel=1, en=1, data=ex_result.
  - MEM hit (priority 2): sel=1, en=1. data=mem_load_data if MEM.is_load, else the MEM value.
  - Otherwise: sel=0, en=1, data=0.
- When both entries hit, EXE wins because it is the youngest writer.
- If rs==rt, both operands resolve identically.
- flush takes priority over stall. When flush=1, stall=0 and a bubble is inserted.

## Timing
- Reset (synchronous): entries invalid, all fwd_* outputs 0, and stall 0 in the following cycle.
  - While reset=1, stall is forced to 0.
- Latency is 1 cycle. Decode inputs in cycle N produce fwd_* outputs valid in cycle N+1, which is that instruction's EX cycle.
- stall is combinational from the id_* inputs and the EXE entry, in the same cycle.
  - While stall=1, upstream keeps the id_* inputs stable.
  - A load-use hazard stalls for exactly 1 cycle. In the next cycle the load sits in MEM and forwards via mem_load_data.
- Reset asserted mid-stall clears the stall and all entries. The held instruction is re-presented after reset.

## Configuration
- FWD_MEM_EN: MEM-stage forwarding is compiled in.
  - Defined: behaviour as described above.
  - Undefined: a MEM hit asserts stall instead of forwarding. That stall lasts 1 cycle, after which the register file holds the value (write-through). A load-use hazard then stalls 2 cycles. EXE forwarding is unchanged.

## Test plan
- Reset: hold reset 2 cycles with id_valid=1 and rs=3 matching a pending write -> every output 0 and stall=0 throughout, and 0 on the first cycle after reset.
- EX forward: issue `add r3` (ex_result=0xA), then an instruction with rs=3 -> next cycle fwd_a_sel=1, en=1, data=0xA; fwd_b_sel=0, en=1.
- MEM forward priority:
  - Issue r5<=0x2, then r5<=0x7, then a reader of r5 -> data=0x7 (EXE wins).
  - Issue r5<=0x2, then an unrelated instruction, then a reader of r5 -> data=0x2.
- Load-use: issue a load to r4, then a reader with rt=4 -> stall=1 for 1 cycle and en=0 for the bubble; next cycle fwd_b_sel=1 with data=mem_load_data=0xC. Without FWD_MEM_EN: stall for 2 cycles, then sel=0.
- Register zero and flush:
  - A writer of r0 followed by a reader of r0 -> sel=0, en=1.
  - flush=1 together with a load-use hazard -> stall=0, and next cycle en=0 on both operands.
